can_tx_sched: RTL and testbench

Transmit scheduler for the CAN node. It arbitrates among `2**IDX_W` local transmit mailboxes, each holding an 11-bit identifier. It waits for the bus to go idle, then picks the highest-priority pending mailbox, which in CAN is the lowest ID. It starts the transmitter and then tracks completion, lost arbitration and error frames, with a per-mailbox retry limit. It runs on the one-tick-per-bit sample clock `Clock_SP`, alongside `can_rx` and `can_destuff`, and consumes `Bit_Input` and `Erro_Flag` from that path.

---
 rtl/can_tx_sched_pkg.sv | 28 ++
 rtl/can_prio_sel.sv | 47 ++++
 rtl/can_tx_sched.sv | 191 +++++++++++++++++++
 tb/tb_can_tx_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_sched_pkg.sv
// can_pkg: shared widths, defaults, state encoding and the ID comparison
// helper used by the CAN transmit scheduler and its priority selector.
package can_pkg;

  localparam int CAN_ID_W      = 11;
  localparam int IDLE_BITS_DEF = 11;
  localparam int MAX_RETRY_DEF = 8;
  // Width shared by the idle counter and the per-mailbox retry counters.
  localparam int CNT_W         = 4;

  typedef enum logic [0:0] {
    WAIT_IDLE = 1'b0,
    TX        = 1'b1
  } tx_state_t;

  // True when candidate b should replace candidate a: b is valid and either
  // a is empty or b carries a strictly lower (higher-priority) ID. Equal IDs
  // keep a, so the lower-index side of every compare stage wins ties.
  function automatic logic b_beats_a(
    input logic                a_v,
    input logic [CAN_ID_W-1:0] a_id,
    input logic                b_v,
    input logic [CAN_ID_W-1:0] b_id
  );
    return b_v && (!a_v || (b_id < a_id));
  endfunction

endpackage

// File: rtl/can_prio_sel.sv
// can_prio_sel: combinational minimum-ID selector. Pairs of candidates are
// reduced level by level; the even (lower-index) slot of each pair keeps the
// win on equal IDs, which gives lowest-index tie-break across the tree.
module can_prio_sel
  import can_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [(2**IDX_W)-1:0]          elig,
  input  logic [CAN_ID_W*(2**IDX_W)-1:0] ids,
  output logic                           sel_valid,
  output logic [IDX_W-1:0]               sel_idx,
  output logic [CAN_ID_W-1:0]            sel_id
);

  localparam int NUM = 2**IDX_W;

  logic [NUM-1:0]      node_v_s;
  logic [CAN_ID_W-1:0] node_id_s [NUM];
  logic [IDX_W-1:0]    node_ix_s [NUM];

  // Compare tree: level l folds slots 2j/2j+1 into slot j, in place.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      node_v_s[i]  = elig[i];
      node_id_s[i] = ids[CAN_ID_W*i +: CAN_ID_W];
      node_ix_s[i] = IDX_W'(i);
    end
    for (int l = 0; l < IDX_W; l++) begin
      for (int j = 0; j < (NUM >> (l + 1)); j++) begin
        if (b_beats_a(node_v_s[2*j], node_id_s[2*j], node_v_s[2*j+1], node_id_s[2*j+1])) begin
          node_id_s[j] = node_id_s[2*j+1];
          node_ix_s[j] = node_ix_s[2*j+1];
        end else begin
          node_id_s[j] = node_id_s[2*j];
          node_ix_s[j] = node_ix_s[2*j];
        end
        node_v_s[j] = node_v_s[2*j] | node_v_s[2*j+1];
      end
    end
  end

  assign sel_valid = node_v_s[0];
  assign sel_idx   = node_ix_s[0];
  assign sel_id    = node_id_s[0];

endmodule

// File: rtl/can_tx_sched.sv
// can_tx_sched: CAN transmit scheduler on the bit-rate sample clock. Waits for
// IDLE_BITS recessive bits, launches the lowest-ID eligible mailbox and then
// resolves the frame as done, lost arbitration or error, with a per-mailbox
// retry limit that parks a mailbox until its requester drops Req.
module can_tx_sched
  import can_pkg::*;
#(
  parameter int IDX_W     = 2,
  parameter int IDLE_BITS = IDLE_BITS_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                           Clock_SP,
  input  logic                           Reset_N,
  input  logic                           Bit_Input,
  input  logic                           Erro_Flag,
  input  logic [(2**IDX_W)-1:0]          Req,
  input  logic [CAN_ID_W*(2**IDX_W)-1:0] Req_Id,
  input  logic                           Tx_Done,
  input  logic                           Tx_Lost,
  output logic                           Tx_Start,
  output logic [CAN_ID_W-1:0]            Tx_Id,
  output logic [IDX_W-1:0]               Tx_Sel,
  output logic                           Busy,
  output logic [(2**IDX_W)-1:0]          Ack,
  output logic [(2**IDX_W)-1:0]          Fail
);

  localparam int               NUM_MBOX    = 2**IDX_W;
  localparam logic [CNT_W-1:0] IDLE_MAX    = CNT_W'(IDLE_BITS);
  localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

  tx_state_t           state_r;
  logic [CNT_W-1:0]    idle_cnt_r;
  logic [CNT_W-1:0]    retry_r [NUM_MBOX];
  logic [NUM_MBOX-1:0] fail_mask_r;

  logic [NUM_MBOX-1:0] elig_s;
  logic                sel_valid_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [CAN_ID_W-1:0] sel_id_s;

  logic                go_s;
  logic                ev_err_s;
  logic                ev_lost_s;
  logic                ev_done_s;
  logic                leave_s;
  logic [CNT_W-1:0]    retry_next_s;
  logic                retry_hit_s;

  // A mailbox parked by the retry limit stays out of arbitration until its
  // requester withdraws.
  assign elig_s = Req & ~fail_mask_r;

  can_prio_sel #(
    .IDX_W (IDX_W)
  ) u_prio_sel (
    .elig      (elig_s),
    .ids       (Req_Id),
    .sel_valid (sel_valid_s),
    .sel_idx   (sel_idx_s),
    .sel_id    (sel_id_s)
  );

  // Retry bookkeeping is always about the mailbox currently on the bus.
  assign retry_next_s = retry_r[Tx_Sel] + 4'd1;
  assign retry_hit_s  = (retry_next_s == RETRY_LIMIT);
  assign leave_s      = ev_err_s | ev_lost_s | ev_done_s;

  // Decode this edge's action: launch in WAIT_IDLE, prioritised outcome in TX.
  always_comb begin
    go_s      = 1'b0;
    ev_err_s  = 1'b0;
    ev_lost_s = 1'b0;
    ev_done_s = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if ((idle_cnt_r == IDLE_MAX) && sel_valid_s) begin
          go_s = 1'b1;
        end else begin
          go_s = 1'b0;
        end
      end
      TX: begin
        if (Erro_Flag) begin
          ev_err_s = 1'b1;
        end else if (Tx_Lost) begin
          ev_lost_s = 1'b1;
        end else if (Tx_Done) begin
          ev_done_s = 1'b1;
        end else begin
          ev_done_s = 1'b0;
        end
      end
      default: begin
        go_s = 1'b0;
      end
    endcase
  end

  // Idle counter: run length of recessive bits, held at zero while a frame is
  // in flight so that every return to WAIT_IDLE starts counting from scratch.
  always_ff @(posedge Clock_SP or negedge Reset_N) begin
    if (!Reset_N) begin
      idle_cnt_r <= 4'd0;
    end else if (state_r == TX) begin
      idle_cnt_r <= 4'd0;
    end else if (!Bit_Input) begin
      idle_cnt_r <= 4'd0;
    end else if (idle_cnt_r != IDLE_MAX) begin
      idle_cnt_r <= idle_cnt_r + 4'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Retry counters and fail mask; a limit hit re-parks the mailbox even if its
  // Req is low on that same edge, and the low Req then clears it next edge.
  always_ff @(posedge Clock_SP or negedge Reset_N) begin
    if (!Reset_N) begin
      fail_mask_r <= '0;
      for (int i = 0; i < NUM_MBOX; i++) begin
        retry_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MBOX; i++) begin
        if (ev_err_s && retry_hit_s && (Tx_Sel == IDX_W'(i))) begin
          fail_mask_r[i] <= 1'b1;
        end else begin
          fail_mask_r[i] <= fail_mask_r[i] & Req[i];
        end
      end
      if (ev_err_s) begin
        retry_r[Tx_Sel] <= retry_hit_s ? 4'd0 : retry_next_s;
      end else if (ev_done_s) begin
        retry_r[Tx_Sel] <= 4'd0;
      end else begin
        retry_r[Tx_Sel] <= retry_r[Tx_Sel];
      end
    end
  end

  // Scheduler FSM with registered start/busy/selection and one-cycle pulses.
  always_ff @(posedge Clock_SP or negedge Reset_N) begin
    if (!Reset_N) begin
      state_r  <= WAIT_IDLE;
      Tx_Start <= 1'b0;
      Busy     <= 1'b0;
      Tx_Id    <= 11'd0;
      Tx_Sel   <= '0;
      Ack      <= '0;
      Fail     <= '0;
    end else begin
      Tx_Start <= 1'b0;
      Ack      <= '0;
      Fail     <= '0;
      case (state_r)
        WAIT_IDLE: begin
          if (go_s) begin
            state_r  <= TX;
            Tx_Start <= 1'b1;
            Busy     <= 1'b1;
            Tx_Sel   <= sel_idx_s;
            Tx_Id    <= sel_id_s;
          end else begin
            state_r <= WAIT_IDLE;
          end
        end
        TX: begin
          if (ev_err_s && retry_hit_s) begin
            Fail[Tx_Sel] <= 1'b1;
          end else if (ev_done_s) begin
            Ack[Tx_Sel] <= 1'b1;
          end else begin
            Ack <= '0;
          end
          if (leave_s) begin
            state_r <= WAIT_IDLE;
            Busy    <= 1'b0;
          end else begin
            state_r <= TX;
          end
        end
        default: begin
          state_r <= WAIT_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_sched.sv
// tb_can_tx_sched: directed scenarios plus randomized traffic. A reference
// model steps the scheduling rules once per bit and queues expected Tx_Start,
// Ack and Fail events stamped with their cycle; a monitor pops and compares
// whenever the DUT pulses, and checks Busy/selection every cycle.
`timescale 1ns/1ps
module tb_can_tx_sched;

  localparam int IDX_W     = 2;
  localparam int NUM       = 4;
  localparam int IDLE_BITS = 11;
  localparam int MAX_RETRY = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_in = 1'b1;
  logic             err = 1'b0;
  logic             lost = 1'b0;
  logic             done = 1'b0;
  logic [NUM-1:0]   req = '0;
  logic [10:0]      ids [NUM];
  logic [11*NUM-1:0] req_id;
  logic             tx_start;
  logic             busy;
  logic [10:0]      tx_id;
  logic [IDX_W-1:0] tx_sel;
  logic [NUM-1:0]   ack;
  logic [NUM-1:0]   fail;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fail_seen [NUM];

  typedef struct {
    int cyc;
    int idx;
    int id;
  } ev_t;
  ev_t q_start[$];
  ev_t q_ack[$];
  ev_t q_fail[$];

  // reference model state
  int m_run = 0;
  bit m_tx  = 1'b0;
  int m_sel = 0;
  int m_id  = 0;
  int m_retry [NUM];
  bit m_mask  [NUM];

  assign req_id = {ids[3], ids[2], ids[1], ids[0]};

  always #5 clk = ~clk;

  can_tx_sched #(
    .IDX_W     (IDX_W),
    .IDLE_BITS (IDLE_BITS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .Clock_SP  (clk),
    .Reset_N   (rst_n),
    .Bit_Input (bit_in),
    .Erro_Flag (err),
    .Req       (req),
    .Req_Id    (req_id),
    .Tx_Done   (done),
    .Tx_Lost   (lost),
    .Tx_Start  (tx_start),
    .Tx_Id     (tx_id),
    .Tx_Sel    (tx_sel),
    .Busy      (busy),
    .Ack       (ack),
    .Fail      (fail)
  );

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", nm, got, got, exp, exp, cyc);
    end
  endtask

  // One bus bit of the model: what the rules say happens at this edge.
  task automatic model_step();
    int  best;
    ev_t e;
    for (int i = 0; i < NUM; i++) if (!req[i]) m_mask[i] = 1'b0;
    if (!m_tx) begin
      best = -1;
      if (m_run == IDLE_BITS) begin
        for (int i = 0; i < NUM; i++) begin
          if (req[i] && !m_mask[i] && (best < 0 || ids[i] < ids[best])) best = i;
        end
      end
      if (best >= 0) begin
        m_tx = 1'b1; m_sel = best; m_id = int'(ids[best]); m_run = 0;
        e.cyc = cyc; e.idx = best; e.id = m_id;
        q_start.push_back(e);
      end else begin
        m_run = bit_in ? ((m_run < IDLE_BITS) ? m_run + 1 : IDLE_BITS) : 0;
      end
    end else if (err) begin
      m_retry[m_sel]++;
      if (m_retry[m_sel] == MAX_RETRY) begin
        e.cyc = cyc; e.idx = m_sel; e.id = 0;
        q_fail.push_back(e);
        m_retry[m_sel] = 0;
        m_mask[m_sel]  = 1'b1;
      end
      m_tx = 1'b0; m_run = 0;
    end else if (lost) begin
      m_tx = 1'b0; m_run = 0;
    end else if (done) begin
      e.cyc = cyc; e.idx = m_sel; e.id = 0;
      q_ack.push_back(e);
      m_retry[m_sel] = 0;
      m_tx = 1'b0; m_run = 0;
    end
  endtask

  // Model process: reset is immediate, otherwise one step per rising edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_tx = 1'b0; m_sel = 0; m_id = 0;
        for (int i = 0; i < NUM; i++) begin m_retry[i] = 0; m_mask[i] = 1'b0; end
      end else begin
        cyc++;
        model_step();
      end
    end
  end

  // Monitor: compare just after each rising edge.
  initial begin
    ev_t            e;
    logic [NUM-1:0] exp_v;
    for (int i = 0; i < NUM; i++) fail_seen[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) if (fail[i]) fail_seen[i]++;
      chk("busy", int'(busy), int'(m_tx));
      if (m_tx) begin
        chk("held_sel", int'(tx_sel), m_sel);
        chk("held_id", int'(tx_id), m_id);
      end
      if (tx_start === 1'b1) begin
        if (q_start.size() == 0 || q_start[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL start_unexpected: got Tx_Start sel=%0d id=0x%0h required no start at cycle %0d", tx_sel, tx_id, cyc);
        end else begin
          e = q_start.pop_front();
          chk("start_sel", int'(tx_sel), e.idx);
          chk("start_id", int'(tx_id), e.id);
        end
      end
      if (q_start.size() != 0 && q_start[0].cyc <= cyc) begin
        e = q_start.pop_front();
        total++; bad++;
        $display("FAIL start_missing: got no Tx_Start required sel=%0d id=0x%0h at cycle %0d", e.idx, e.id, e.cyc);
      end
      if (ack !== '0) begin
        if (q_ack.size() == 0 || q_ack[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got Ack=%b required 0 at cycle %0d", ack, cyc);
        end else begin
          e = q_ack.pop_front();
          exp_v = 4'b0001 << e.idx;
          chk("ack_vec", int'(ack), int'(exp_v));
        end
      end
      if (q_ack.size() != 0 && q_ack[0].cyc <= cyc) begin
        e = q_ack.pop_front();
        total++; bad++;
        $display("FAIL ack_missing: got Ack=%b required mailbox %0d at cycle %0d", ack, e.idx, e.cyc);
      end
      if (fail !== '0) begin
        if (q_fail.size() == 0 || q_fail[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL fail_unexpected: got Fail=%b required 0 at cycle %0d", fail, cyc);
        end else begin
          e = q_fail.pop_front();
          exp_v = 4'b0001 << e.idx;
          chk("fail_vec", int'(fail), int'(exp_v));
        end
      end
      if (q_fail.size() != 0 && q_fail[0].cyc <= cyc) begin
        e = q_fail.pop_front();
        total++; bad++;
        $display("FAIL fail_missing: got Fail=%b required mailbox %0d at cycle %0d", fail, e.idx, e.cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    err = 1'b0; lost = 1'b0; done = 1'b0;
  endtask

  task automatic wait_busy(input string nm, input int lim, output int k);
    k = 0;
    while (busy !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: got Busy=%b required 1 within %0d cycles", nm, busy, lim);
    end
  endtask

  function automatic logic [10:0] pick_id();
    case ($urandom_range(0, 4))
      0:       return 11'h000;
      1:       return 11'h0FF;
      2:       return 11'h123;
      3:       return 11'h7FF;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int k;
    int base;
    int drop_t [NUM];
    int r;
    for (int i = 0; i < NUM; i++) begin ids[i] = 11'h000; drop_t[i] = 0; end

    // reset values
    repeat (3) tick();
    chk("rst_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_id", int'(tx_id), 0);
    chk("rst_sel", int'(tx_sel), 0);

    // single request
    rst_n = 1'b1; bit_in = 1'b1;
    ids[0] = 11'h123; req = 4'b0001;
    wait_busy("single", 30, k);
    chk("single_latency", k, IDLE_BITS + 1);
    chk("single_sel", int'(tx_sel), 0);
    chk("single_id", int'(tx_id), 'h123);
    done = 1'b1; tick();
    chk("single_ack", int'(ack), 1);
    chk("single_busy_clr", int'(busy), 0);
    req = 4'b0000;

    // priority and tie
    ids[0] = 11'h200; ids[1] = 11'h0FF; ids[2] = 11'h0FF; ids[3] = 11'h7FF;
    req = 4'b1111;
    wait_busy("prio", 30, k);
    chk("prio_latency", k, IDLE_BITS + 1);
    chk("prio_sel", int'(tx_sel), 1);
    chk("prio_id", int'(tx_id), 'h0FF);
    done = 1'b1; tick();
    req[1] = 1'b0;
    wait_busy("tie", 30, k);
    chk("tie_sel", int'(tx_sel), 2);
    done = 1'b1; tick();
    req = 4'b0000;

    // idle restart
    ids[0] = 11'h321; req = 4'b0001;
    repeat (10) tick();
    bit_in = 1'b0; tick();
    bit_in = 1'b1;
    wait_busy("restart", 30, k);
    chk("restart_latency", k, IDLE_BITS + 1);
    done = 1'b1; tick();
    req = 4'b0000;

    // retry limit on mailbox 2
    ids[2] = 11'h055; req = 4'b0100;
    base = fail_seen[2];
    for (int n = 0; n < MAX_RETRY; n++) begin
      wait_busy("retry", 30, k);
      chk("retry_sel", int'(tx_sel), 2);
      err = 1'b1; tick();
    end
    chk("retry_fail_vec", int'(fail), 4);
    chk("retry_fail_count", fail_seen[2] - base, 1);
    ids[0] = 11'h400; req = 4'b0101;
    wait_busy("skip", 30, k);
    chk("skip_sel", int'(tx_sel), 0);
    done = 1'b1; tick();
    req[0] = 1'b0; req[2] = 1'b0; tick();
    req[2] = 1'b1;
    wait_busy("rearm", 30, k);
    chk("rearm_sel", int'(tx_sel), 2);
    lost = 1'b1; tick();
    wait_busy("lost", 30, k);
    chk("lost_latency", k, IDLE_BITS + 1);
    chk("lost_sel", int'(tx_sel), 2);
    err = 1'b1; done = 1'b1; tick();
    chk("collide_no_ack", int'(ack), 0);
    base = fail_seen[2];
    for (int n = 0; n < MAX_RETRY - 1; n++) begin
      wait_busy("retry2", 30, k);
      err = 1'b1; tick();
    end
    chk("retry2_fail_count", fail_seen[2] - base, 1);
    req = 4'b0000; tick();

    // mid-frame reset
    ids[1] = 11'h0AA; req = 4'b0010;
    wait_busy("midrst", 30, k);
    done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_start", int'(tx_start), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_fail", int'(fail), 0);
    tick(); tick();
    rst_n = 1'b1;
    wait_busy("postrst", 30, k);
    chk("postrst_latency", k, IDLE_BITS + 1);
    done = 1'b1; tick();
    req = 4'b0000;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      bit_in = ($urandom_range(0, 99) < 88);
      if (busy) begin
        r    = $urandom_range(0, 99);
        err  = (r < 12);
        lost = (r >= 8 && r < 20);
        done = (r >= 15 && r < 40);
      end else begin
        err  = ($urandom_range(0, 29) == 0);
        lost = ($urandom_range(0, 29) == 0);
        done = ($urandom_range(0, 29) == 0);
      end
      for (int i = 0; i < NUM; i++) begin
        if (ack[i]) drop_t[i] = $urandom_range(1, 5);
        else if (fail[i]) drop_t[i] = $urandom_range(1, 30);
        if (drop_t[i] > 0) begin
          drop_t[i]--;
          if (drop_t[i] == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 15) == 0) begin
          ids[i] = pick_id();
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 299) == 0) begin
          req[i] = 1'b0;
        end
      end
    end

    // drain
    req = 4'b0000; bit_in = 1'b1;
    repeat (20) tick();
    chk("drain_start_q", q_start.size(), 0);
    chk("drain_ack_q", q_ack.size(), 0);
    chk("drain_fail_q", q_fail.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
